p3_execute: RTL and testbench

Execute stage (phase 3) of the SIMPLE processor. It consumes the decoded operands and control from the register-read stage, computes the ALU result and the S/Z/C/V condition flags, evaluates branch conditions, and drives the IN/OUT ports. It registers everything the memory and write-back phases need, and freezes the datapath after HLT.

---
 rtl/p3_execute.sv | 216 +++++++++++++++++++++
 tb/tb_p3_execute.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/p3_execute.sv
`default_nettype none
// ============================================================================
// Module      : p3_execute
// Description : Phase-3 execute stage of the SIMPLE processor. Computes the
//               ALU result and S/Z/C/V flags, resolves branches against the
//               previous instruction's flags, drives the IN/OUT ports and
//               registers pass-through control. Freezes after HLT.
// Revision    : 1.0 - initial release
// ============================================================================
module p3_execute #(
  parameter int WIDTH = 16
) (
  input  logic             clockp3,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu1,
  input  logic [WIDTH-1:0] alu2,
  input  logic [3:0]       opcode,
  input  logic             writereg,
  input  logic [1:0]       memwrite,
  input  logic [2:0]       regaddress,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] storedata,
  input  logic             isbranch,
  input  logic [2:0]       cond,
  input  logic [WIDTH-1:0] pcp2,
  input  logic             halt,
  input  logic [WIDTH-1:0] indata,
  output logic [WIDTH-1:0] aluresult,
  output logic [3:0]       flags,
  output logic             writeregout,
  output logic [1:0]       memwriteout,
  output logic [2:0]       regaddressout,
  output logic [WIDTH-1:0] addressout,
  output logic [WIDTH-1:0] storedataout,
  output logic             branchtaken,
  output logic [WIDTH-1:0] branchtarget,
  output logic [WIDTH-1:0] outdata,
  output logic             outvalid,
  output logic             haltout
);

  localparam logic [3:0] c_op_add = 4'b0000;
  localparam logic [3:0] c_op_sub = 4'b0001;
  localparam logic [3:0] c_op_and = 4'b0010;
  localparam logic [3:0] c_op_or  = 4'b0011;
  localparam logic [3:0] c_op_xor = 4'b0100;
  localparam logic [3:0] c_op_cmp = 4'b0101;
  localparam logic [3:0] c_op_mov = 4'b0110;
  localparam logic [3:0] c_op_sll = 4'b1000;
  localparam logic [3:0] c_op_slr = 4'b1001;
  localparam logic [3:0] c_op_srl = 4'b1010;
  localparam logic [3:0] c_op_sra = 4'b1011;
  localparam logic [3:0] c_op_in  = 4'b1100;
  localparam logic [3:0] c_op_out = 4'b1101;
  localparam logic [3:0] c_op_hlt = 4'b1111;

  typedef enum logic [0:0] {
    c_run    = 1'b0,
    c_halted = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_aluresult, r_addressout, r_storedataout, r_branchtarget, r_outdata;
  logic [3:0]         r_flags;
  logic               r_writeregout, r_branchtaken, r_outvalid, r_haltout;
  logic [1:0]         r_memwriteout;
  logic [2:0]         r_regaddressout;

  logic [WIDTH-1:0]   w_r;
  logic               w_c, w_v, w_setflags;
  logic [WIDTH:0]     w_ext;
  logic [2*WIDTH-1:0] w_rot;
  logic [3:0]         w_n;
  logic [3:0]         w_flags_nxt;
  logic               w_cond_ok, w_taken, w_halting;

  assign w_n = alu2[3:0];

  // ALU: result, carry/borrow and overflow for the current opcode
  always_comb begin
    w_r        = '0;
    w_c        = 1'b0;
    w_v        = 1'b0;
    w_setflags = 1'b0;
    w_ext      = '0;
    w_rot      = '0;
    case (opcode)
      c_op_add: begin
        w_ext      = {1'b0, alu1} + {1'b0, alu2};
        w_r        = w_ext[WIDTH-1:0];
        w_c        = w_ext[WIDTH];
        w_v        = (alu1[WIDTH-1] == alu2[WIDTH-1]) && (w_r[WIDTH-1] != alu1[WIDTH-1]);
        w_setflags = 1'b1;
      end
      c_op_sub, c_op_cmp: begin
        w_r        = alu1 - alu2;
        w_c        = (alu1 < alu2);
        w_v        = (alu1[WIDTH-1] != alu2[WIDTH-1]) && (w_r[WIDTH-1] != alu1[WIDTH-1]);
        w_setflags = 1'b1;
      end
      c_op_and: begin w_r = alu1 & alu2; w_setflags = 1'b1; end
      c_op_or:  begin w_r = alu1 | alu2; w_setflags = 1'b1; end
      c_op_xor: begin w_r = alu1 ^ alu2; w_setflags = 1'b1; end
      c_op_mov: begin w_r = alu1;        w_setflags = 1'b1; end
      // Extra bit beyond the shifted word captures the last bit shifted out
      c_op_sll: begin
        w_ext      = {1'b0, alu1} << w_n;
        w_r        = w_ext[WIDTH-1:0];
        w_c        = w_ext[WIDTH];
        w_setflags = 1'b1;
      end
      c_op_srl: begin
        w_ext      = {alu1, 1'b0} >> w_n;
        w_r        = w_ext[WIDTH:1];
        w_c        = w_ext[0];
        w_setflags = 1'b1;
      end
      c_op_sra: begin
        w_ext      = $signed({alu1, 1'b0}) >>> w_n;
        w_r        = w_ext[WIDTH:1];
        w_c        = w_ext[0];
        w_setflags = 1'b1;
      end
      // Rotate left: upper half of the doubled word after a left shift
      c_op_slr: begin
        w_rot      = {alu1, alu1} << w_n;
        w_r        = w_rot[2*WIDTH-1:WIDTH];
        w_setflags = 1'b1;
      end
      c_op_in:  w_r = indata;
      default:  w_r = '0;
    endcase
  end

  // Flag update, branch resolution on the previous flags, halt detection
  always_comb begin
    w_flags_nxt = w_setflags ? {w_r[WIDTH-1], (w_r == '0), w_c, w_v} : r_flags;
    case (cond)
      3'b000:  w_cond_ok = r_flags[2];
      3'b001:  w_cond_ok = r_flags[3] ^ r_flags[0];
      3'b010:  w_cond_ok = r_flags[2] | (r_flags[3] ^ r_flags[0]);
      3'b011:  w_cond_ok = ~r_flags[2];
      3'b100:  w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
    w_taken   = isbranch & w_cond_ok;
    w_halting = halt | (opcode == c_op_hlt);
  end

  // Next-state: RUN moves to HALTED on any halt request; HALTED is terminal
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == c_run && w_halting) begin
      w_state_nxt = c_halted;
    end
  end

  // State register
  always_ff @(posedge clockp3 or negedge reset) begin
    if (!reset) r_state <= c_run;
    else        r_state <= w_state_nxt;
  end

  // Output registers; a halt request on this edge is treated like HALTED
  always_ff @(posedge clockp3 or negedge reset) begin
    if (!reset) begin
      r_aluresult     <= '0;
      r_flags         <= '0;
      r_writeregout   <= 1'b0;
      r_memwriteout   <= '0;
      r_regaddressout <= '0;
      r_addressout    <= '0;
      r_storedataout  <= '0;
      r_branchtaken   <= 1'b0;
      r_branchtarget  <= '0;
      r_outdata       <= '0;
      r_outvalid      <= 1'b0;
      r_haltout       <= 1'b0;
    end else if (r_state == c_halted || w_halting) begin
      r_writeregout <= 1'b0;
      r_memwriteout <= '0;
      r_branchtaken <= 1'b0;
      r_outvalid    <= 1'b0;
      r_haltout     <= 1'b1;
    end else begin
      r_aluresult     <= w_r;
      r_flags         <= w_flags_nxt;
      r_writeregout   <= writereg & ~w_taken & (opcode != c_op_cmp);
      r_memwriteout   <= w_taken ? 2'b00 : memwrite;
      r_regaddressout <= regaddress;
      r_addressout    <= address;
      r_storedataout  <= storedata;
      r_branchtaken   <= w_taken;
      r_branchtarget  <= pcp2 + address;
      r_outvalid      <= (opcode == c_op_out);
      if (opcode == c_op_out) begin
        r_outdata <= alu1;
      end
    end
  end

  assign aluresult     = r_aluresult;
  assign flags         = r_flags;
  assign writeregout   = r_writeregout;
  assign memwriteout   = r_memwriteout;
  assign regaddressout = r_regaddressout;
  assign addressout    = r_addressout;
  assign storedataout  = r_storedataout;
  assign branchtaken   = r_branchtaken;
  assign branchtarget  = r_branchtarget;
  assign outdata       = r_outdata;
  assign outvalid      = r_outvalid;
  assign haltout       = r_haltout;

endmodule
`default_nettype wire

// File: tb/tb_p3_execute.sv
`default_nettype none
// ============================================================================
// Module      : tb_p3_execute
// Description : Directed self-checking bench for the p3_execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p3_execute;

  logic        clockp3 = 1'b0;
  logic        reset;
  logic [15:0] alu1, alu2, address, storedata, pcp2, indata;
  logic [3:0]  opcode;
  logic        writereg, isbranch, halt;
  logic [1:0]  memwrite;
  logic [2:0]  regaddress, cond;
  logic [15:0] aluresult, addressout, storedataout, branchtarget, outdata;
  logic [3:0]  flags;
  logic        writeregout, branchtaken, outvalid, haltout;
  logic [1:0]  memwriteout;
  logic [2:0]  regaddressout;

  int n_checks = 0;
  int n_errors = 0;

  p3_execute #(.WIDTH(16)) dut (
    .clockp3(clockp3), .reset(reset),
    .alu1(alu1), .alu2(alu2), .opcode(opcode),
    .writereg(writereg), .memwrite(memwrite), .regaddress(regaddress),
    .address(address), .storedata(storedata),
    .isbranch(isbranch), .cond(cond), .pcp2(pcp2), .halt(halt), .indata(indata),
    .aluresult(aluresult), .flags(flags),
    .writeregout(writeregout), .memwriteout(memwriteout),
    .regaddressout(regaddressout), .addressout(addressout), .storedataout(storedataout),
    .branchtaken(branchtaken), .branchtarget(branchtarget),
    .outdata(outdata), .outvalid(outvalid), .haltout(haltout)
  );

  always #5 clockp3 = ~clockp3;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Load an instruction with neutral control defaults
  task automatic ld(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    opcode = op; alu1 = a; alu2 = b;
    writereg = 1'b1; memwrite = 2'b00; regaddress = 3'd0;
    address = 16'h0000; storedata = 16'h0000; pcp2 = 16'h0000;
    isbranch = 1'b0; cond = 3'b000; halt = 1'b0; indata = 16'h0000;
  endtask

  // One instruction per edge; sample 1 time unit after the edge
  task automatic tick;
    @(posedge clockp3);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    ld(4'b0111, 16'h0, 16'h0);
    #2;
    check_eq("rst_aluresult", aluresult, 16'h0000);
    check_eq("rst_flags", {12'h0, flags}, 16'h0000);
    check_eq("rst_haltout", {15'h0, haltout}, 16'h0000);
    check_eq("rst_outvalid", {15'h0, outvalid}, 16'h0000);
    #10 reset = 1'b1;

    // ADD with signed overflow, plus pass-through fields
    ld(4'b0000, 16'h7FFF, 16'h0001);
    regaddress = 3'd5; address = 16'h0042; storedata = 16'hBEEF; memwrite = 2'b10;
    tick;
    check_eq("add_ovf_r", aluresult, 16'h8000);
    check_eq("add_ovf_f", {12'h0, flags}, 16'h0009);
    check_eq("add_wr", {15'h0, writeregout}, 16'h0001);
    check_eq("add_mw", {14'h0, memwriteout}, 16'h0002);
    check_eq("add_ra", {13'h0, regaddressout}, 16'h0005);
    check_eq("add_addr", addressout, 16'h0042);
    check_eq("add_sd", storedataout, 16'hBEEF);

    ld(4'b0000, 16'hFFFF, 16'h0001); tick;
    check_eq("add_carry_r", aluresult, 16'h0000);
    check_eq("add_carry_f", {12'h0, flags}, 16'h0006);

    ld(4'b0001, 16'h0003, 16'h0005); tick;
    check_eq("sub_r", aluresult, 16'hFFFE);
    check_eq("sub_f", {12'h0, flags}, 16'h000A);

    ld(4'b0101, 16'h1234, 16'h1234); tick;
    check_eq("cmp_f", {12'h0, flags}, 16'h0004);
    check_eq("cmp_wr", {15'h0, writeregout}, 16'h0000);

    // BE after equal compare: taken, suppresses writes
    ld(4'b0111, 16'h0, 16'h0);
    isbranch = 1'b1; cond = 3'b000; pcp2 = 16'h0010; address = 16'hFFF8; memwrite = 2'b01;
    tick;
    check_eq("be_taken", {15'h0, branchtaken}, 16'h0001);
    check_eq("be_target", branchtarget, 16'h0008);
    check_eq("be_wr", {15'h0, writeregout}, 16'h0000);
    check_eq("be_mw", {14'h0, memwriteout}, 16'h0000);

    ld(4'b0111, 16'h0, 16'h0);
    isbranch = 1'b1; cond = 3'b011; pcp2 = 16'h0010; address = 16'hFFF8; memwrite = 2'b01;
    tick;
    check_eq("bne_taken", {15'h0, branchtaken}, 16'h0000);
    check_eq("bne_wr", {15'h0, writeregout}, 16'h0001);
    check_eq("bne_mw", {14'h0, memwriteout}, 16'h0001);
    check_eq("bne_flags_kept", {12'h0, flags}, 16'h0004);

    // Shifts
    ld(4'b1011, 16'h8001, 16'h0001); tick;
    check_eq("sra_r", aluresult, 16'hC000);
    check_eq("sra_f", {12'h0, flags}, 16'h000A);
    ld(4'b1000, 16'h8000, 16'h0001); tick;
    check_eq("sll_r", aluresult, 16'h0000);
    check_eq("sll_f", {12'h0, flags}, 16'h0006);
    ld(4'b1001, 16'h8001, 16'h0004); tick;
    check_eq("slr_r", aluresult, 16'h0018);
    check_eq("slr_f", {12'h0, flags}, 16'h0000);
    ld(4'b1010, 16'h1234, 16'h0000); tick;
    check_eq("srl0_r", aluresult, 16'h1234);
    check_eq("srl0_f", {12'h0, flags}, 16'h0000);
    ld(4'b1010, 16'h0003, 16'h0001); tick;
    check_eq("srl1_r", aluresult, 16'h0001);
    check_eq("srl1_f", {12'h0, flags}, 16'h0002);

    ld(4'b0100, 16'hFF00, 16'h0FF0); tick;
    check_eq("xor_r", aluresult, 16'hF0F0);
    check_eq("xor_f", {12'h0, flags}, 16'h0008);

    // BLT / BLE / never on S=1,V=0
    ld(4'b0111, 16'h0, 16'h0);
    isbranch = 1'b1; cond = 3'b001; pcp2 = 16'h0100; address = 16'h0020; tick;
    check_eq("blt_taken", {15'h0, branchtaken}, 16'h0001);
    check_eq("blt_target", branchtarget, 16'h0120);
    isbranch = 1'b1; cond = 3'b010; tick;
    check_eq("ble_taken", {15'h0, branchtaken}, 16'h0001);
    isbranch = 1'b1; cond = 3'b101; tick;
    check_eq("bnever_taken", {15'h0, branchtaken}, 16'h0000);

    // OUT then IN
    ld(4'b1101, 16'h00AB, 16'h0); tick;
    check_eq("out_data", outdata, 16'h00AB);
    check_eq("out_valid", {15'h0, outvalid}, 16'h0001);
    check_eq("out_r", aluresult, 16'h0000);
    ld(4'b1100, 16'h0, 16'h0); indata = 16'h5A5A; tick;
    check_eq("in_r", aluresult, 16'h5A5A);
    check_eq("in_valid_drop", {15'h0, outvalid}, 16'h0000);
    check_eq("in_outdata_hold", outdata, 16'h00AB);
    check_eq("in_f", {12'h0, flags}, 16'h0008);

    // halt together with OUT: halt wins
    ld(4'b1101, 16'h1111, 16'h0); halt = 1'b1; tick;
    check_eq("hltout_valid", {15'h0, outvalid}, 16'h0000);
    check_eq("hltout_data", outdata, 16'h00AB);
    check_eq("hlt_haltout", {15'h0, haltout}, 16'h0001);
    check_eq("hlt_wr", {15'h0, writeregout}, 16'h0000);

    ld(4'b0000, 16'h0001, 16'h0001); memwrite = 2'b10; isbranch = 1'b1; cond = 3'b100; tick;
    check_eq("halted_haltout", {15'h0, haltout}, 16'h0001);
    check_eq("halted_wr", {15'h0, writeregout}, 16'h0000);
    check_eq("halted_mw", {14'h0, memwriteout}, 16'h0000);
    check_eq("halted_bt", {15'h0, branchtaken}, 16'h0000);
    check_eq("halted_f", {12'h0, flags}, 16'h0008);
    check_eq("halted_r", aluresult, 16'h5A5A);

    // Asynchronous reset in mid-cycle
    #2 reset = 1'b0;
    #1;
    check_eq("areset_r", aluresult, 16'h0000);
    check_eq("areset_f", {12'h0, flags}, 16'h0000);
    check_eq("areset_haltout", {15'h0, haltout}, 16'h0000);
    check_eq("areset_outdata", outdata, 16'h0000);
    #2 reset = 1'b1;

    ld(4'b0000, 16'h0002, 16'h0003); memwrite = 2'b10; tick;
    check_eq("post_add_r", aluresult, 16'h0005);
    check_eq("post_add_f", {12'h0, flags}, 16'h0000);
    check_eq("post_add_wr", {15'h0, writeregout}, 16'h0001);
    check_eq("post_add_mw", {14'h0, memwriteout}, 16'h0002);
    check_eq("post_add_halt", {15'h0, haltout}, 16'h0000);

    // HLT opcode alone
    ld(4'b1111, 16'h0, 16'h0); memwrite = 2'b01; tick;
    check_eq("hltop_haltout", {15'h0, haltout}, 16'h0001);
    check_eq("hltop_wr", {15'h0, writeregout}, 16'h0000);
    check_eq("hltop_mw", {14'h0, memwriteout}, 16'h0000);
    check_eq("hltop_r", aluresult, 16'h0005);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
